// File: rtl/pulse_meter_pkg.sv
// Shared types for the pulse meter.
// FSM states and result field offsets.
package pulse_meter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam int WIDTH_LSB = 0;

  // Period sits directly above the width field.
  function automatic int period_lsb(input int cw);
    return cw;
  endfunction

endpackage

// File: rtl/pulse_meter_if.sv
// Result stream interface (valid/ready).
// master drives tdata/tvalid, slave drives tready.
interface pulse_meter_if #(
  parameter int DW = 64
) ();

  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );

endinterface

// File: rtl/pulse_meter_edge.sv
// din synchronizer plus edge detector.
// Ports: aclk, areset, din in; rise, fall, level out.
module pulse_meter_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic aclk,
  input  logic areset,
  input  logic din,
  output logic rise,
  output logic fall,
  output logic level
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [N-1:0] sync;
  logic [N-1:0] fill;
  logic         prev;
  logic         armed;

  always_ff @(posedge aclk) begin
    if (areset) begin
      sync  <= '0;
      fill  <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
    end else begin
      sync <= {sync[N-2:0], din};
      fill <= {fill[N-2:0], 1'b1};
      prev <= sync[N-1];
      // Edges count only after a real low has been
      // seen, so a din held high across reset is not
      // mistaken for a rise.
      if (fill[N-1] && !sync[N-1])
        armed <= 1'b1;
    end
  end

  assign level = sync[N-1];
  assign rise  = armed & level & ~prev;
  assign fall  = armed & ~level & prev;

endmodule

// File: rtl/pulse_meter.sv
// Pulse width / period meter with one-deep result reg.
// Ports: aclk, areset, cfg, din, m_axis, sts, timeout.
module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int CNTR_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [CNTR_WIDTH-1:0] cfg,
  input  logic                  din,
  pulse_meter_if.master         m_axis,
  output logic [CNTR_WIDTH-1:0] sts,
  output logic                  timeout
);

  localparam int CW = CNTR_WIDTH;
  localparam int PERIOD_LSB = period_lsb(CW);
  localparam logic [CW-1:0] MAX = '1;
  localparam logic [CW-1:0] ONE = {{(CW-1){1'b0}}, 1'b1};

  function automatic logic [CW-1:0] sat_inc(
    input logic [CW-1:0] v
  );
    return (v == MAX) ? v : v + ONE;
  endfunction

  logic rise;
  logic fall;
  logic level;

  pulse_meter_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge (
    .aclk  (aclk),
    .areset(areset),
    .din   (din),
    .rise  (rise),
    .fall  (fall),
    .level (level)
  );

  state_t          state, state_nxt;
  logic [CW-1:0]   wcnt, wcnt_nxt;
  logic [CW-1:0]   pcnt, pcnt_nxt;
  logic [CW-1:0]   wlat, wlat_nxt;
  logic            emit;
  logic            tmo_nxt;
  logic            tmo_hit;
  logic [2*CW-1:0] res;

  // >= keeps a lowered cfg from being skipped over.
  assign tmo_hit = (cfg != '0) && (pcnt >= cfg);

  always_comb begin
    res = '0;
    res[WIDTH_LSB +: CW]  = wlat;
    res[PERIOD_LSB +: CW] = pcnt;
  end

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    pcnt_nxt  = pcnt;
    wlat_nxt  = wlat;
    emit      = 1'b0;
    tmo_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        wcnt_nxt = '0;
        pcnt_nxt = '0;
        if (rise) begin
          state_nxt = HIGH;
          wcnt_nxt  = ONE;
          pcnt_nxt  = ONE;
        end
      end
      HIGH: begin
        pcnt_nxt = sat_inc(pcnt);
        if (level)
          wcnt_nxt = sat_inc(wcnt);
        if (fall) begin
          wlat_nxt  = wcnt;
          state_nxt = LOW;
        end
        if (tmo_hit) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
          wcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end
      end
      LOW: begin
        pcnt_nxt = sat_inc(pcnt);
        if (rise) begin
          emit      = 1'b1;
          state_nxt = HIGH;
          wcnt_nxt  = ONE;
          pcnt_nxt  = ONE;
        end else if (tmo_hit) begin
          state_nxt = IDLE;
          tmo_nxt   = 1'b1;
          wcnt_nxt  = '0;
          pcnt_nxt  = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        wcnt_nxt  = '0;
        pcnt_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
      wcnt  <= '0;
      pcnt  <= '0;
      wlat  <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      pcnt  <= pcnt_nxt;
      wlat  <= wlat_nxt;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      m_axis.tdata  <= '0;
      m_axis.tvalid <= 1'b0;
      sts           <= '0;
      timeout       <= 1'b0;
    end else begin
      timeout <= tmo_nxt;
      if (emit) begin
        // Load when empty or draining this cycle.
        if (!m_axis.tvalid || m_axis.tready) begin
          m_axis.tdata  <= res;
          m_axis.tvalid <= 1'b1;
        end else if (sts != MAX) begin
          sts <= sts + ONE;
        end
      end else if (m_axis.tvalid && m_axis.tready) begin
        m_axis.tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_meter.sv
// Scoreboard bench for pulse_meter.
// Runs a 32-bit and an 8-bit instance.
module tb_pulse_meter;

  localparam int CW  = 32;
  localparam int CW8 = 8;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic [CW-1:0] cfg = '0;
  logic          din = 1'b0;
  logic [CW-1:0] sts;
  logic          timeout;

  logic [CW8-1:0] cfg8 = '0;
  logic           din8 = 1'b0;
  logic [CW8-1:0] sts8;
  logic           timeout8;

  pulse_meter_if #(.DW(2*CW))  m_axis ();
  pulse_meter_if #(.DW(2*CW8)) m_axis8 ();

  pulse_meter #(
    .CNTR_WIDTH (CW),
    .SYNC_STAGES(2)
  ) u_dut (
    .aclk   (aclk),
    .areset (areset),
    .cfg    (cfg),
    .din    (din),
    .m_axis (m_axis),
    .sts    (sts),
    .timeout(timeout)
  );

  pulse_meter #(
    .CNTR_WIDTH (CW8),
    .SYNC_STAGES(2)
  ) u_dut8 (
    .aclk   (aclk),
    .areset (areset),
    .cfg    (cfg8),
    .din    (din8),
    .m_axis (m_axis8),
    .sts    (sts8),
    .timeout(timeout8)
  );

  always #5 aclk = ~aclk;

  int unsigned cyc = 0;
  always @(posedge aclk) cyc++;

  logic [2*CW-1:0]  exp_q[$];
  logic [2*CW8-1:0] exp_q8[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_tmo    = 0;
  int n_tmo8   = 0;
  int unsigned tmo_cyc = 0;
  logic [2*CW-1:0] last_tdata = '0;
  logic            last_stall = 1'b0;

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h",
               name, act, req);
    end
  endtask

  function automatic logic [63:0] res32(
    input logic [31:0] p,
    input logic [31:0] w
  );
    return {p, w};
  endfunction

  always @(negedge aclk) begin
    if (areset) begin
      last_stall = 1'b0;
    end else begin
      if (m_axis.tvalid && m_axis.tready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h required none",
                   m_axis.tdata);
        end else begin
          check("result", m_axis.tdata, exp_q.pop_front());
        end
      end
      if (last_stall)
        check("hold_stable", m_axis.tdata, last_tdata);
      last_stall = m_axis.tvalid && !m_axis.tready;
      last_tdata = m_axis.tdata;
      if (timeout) begin
        n_tmo++;
        tmo_cyc = cyc;
      end
      if (m_axis8.tvalid && m_axis8.tready) begin
        if (exp_q8.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result8: got %0h required none",
                   m_axis8.tdata);
        end else begin
          check("result8", m_axis8.tdata, exp_q8.pop_front());
        end
      end
      if (timeout8)
        n_tmo8++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse(input int hi, input int lo);
    din = 1'b1;
    tick(hi);
    din = 1'b0;
    tick(lo);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    din    = 1'b0;
    din8   = 1'b0;
    tick(2);
    areset = 1'b0;
    tick(5);
  endtask

  int unsigned c0;

  initial begin
    m_axis.tready  = 1'b1;
    m_axis8.tready = 1'b1;
    tick(3);
    check("rst_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("rst_tdata", m_axis.tdata, 64'd0);
    check("rst_sts", 64'(sts), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    areset = 1'b0;
    tick(5);

    // steady 10 high / 30 low, always ready
    cfg = '0;
    pulse(10, 30);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(res32(40, 10));
      pulse(10, 30);
    end
    tick(5);
    check("a_sts", 64'(sts), 64'd0);
    check("a_drain", 64'(exp_q.size()), 64'd0);

    // backpressure: one held result, four drops
    do_reset();
    m_axis.tready = 1'b0;
    exp_q.push_back(res32(40, 10));
    for (int i = 0; i < 5; i++)
      pulse(10, 30);
    din = 1'b1;
    tick(10);
    check("b_sts_drops", 64'(sts), 64'd4);
    check("b_tvalid", 64'(m_axis.tvalid), 64'd1);
    check("b_tdata_held", m_axis.tdata, res32(40, 10));
    m_axis.tready = 1'b1;
    din = 1'b0;
    tick(30);
    exp_q.push_back(res32(40, 10));
    pulse(10, 30);
    tick(5);
    check("b_sts_after", 64'(sts), 64'd4);
    check("b_drain", 64'(exp_q.size()), 64'd0);

    // timeout while stuck high
    do_reset();
    cfg   = 50;
    n_tmo = 0;
    din   = 1'b1;
    c0    = cyc;
    tick(100);
    din = 1'b0;
    tick(20);
    check("c_tmo_count", 64'(n_tmo), 64'd1);
    check("c_tmo_cycle", 64'(tmo_cyc - c0), 64'd53);
    check("c_tvalid", 64'(m_axis.tvalid), 64'd0);

    // rise coinciding with timeout threshold
    do_reset();
    cfg   = 40;
    n_tmo = 0;
    pulse(10, 30);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(res32(40, 10));
      pulse(10, 30);
    end
    exp_q.push_back(res32(40, 10));
    din = 1'b1;
    tick(10);
    din = 1'b0;
    tick(5);
    check("d_no_tmo", 64'(n_tmo), 64'd0);
    tick(40);
    check("d_tmo_low", 64'(n_tmo), 64'd1);
    check("d_drain", 64'(exp_q.size()), 64'd0);

    // reset mid-HIGH with a held result
    do_reset();
    cfg = '0;
    m_axis.tready = 1'b0;
    pulse(10, 30);
    pulse(10, 30);
    din = 1'b1;
    tick(8);
    check("e_pre_tvalid", 64'(m_axis.tvalid), 64'd1);
    areset = 1'b1;
    tick(1);
    check("e_tvalid", 64'(m_axis.tvalid), 64'd0);
    check("e_tdata", m_axis.tdata, 64'd0);
    check("e_sts", 64'(sts), 64'd0);
    check("e_timeout", 64'(timeout), 64'd0);
    m_axis.tready = 1'b1;
    areset = 1'b0;
    tick(20);
    din = 1'b0;
    tick(20);
    pulse(10, 30);
    exp_q.push_back(res32(40, 10));
    din = 1'b1;
    tick(10);
    din = 1'b0;
    tick(10);
    check("e_drain", 64'(exp_q.size()), 64'd0);

    // 8-bit saturation
    do_reset();
    cfg8 = '0;
    din8 = 1'b1;
    tick(300);
    din8 = 1'b0;
    tick(100);
    exp_q8.push_back({8'hff, 8'hff});
    din8 = 1'b1;
    tick(10);
    din8 = 1'b0;
    tick(10);
    check("f_drain", 64'(exp_q8.size()), 64'd0);
    check("f_sts", 64'(sts8), 64'd0);
    check("f_tmo", 64'(n_tmo8), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
